// File: rtl/calc_bcd_seq.sv
// calc_bcd_seq -- registered two-operand calculator with a BCD display path.
//
// Purpose:
//   Latches the operands A = SW[2*OPW-1:OPW] and B = SW[OPW-1:0] when a key press is seen.
//   Computes A+B, |A-B| with a sign flag, A*B, or clear.
//   Converts the result to BCD with an iterative double-dabble loop of RW = 2*OPW steps.
//   Drives DIGITS active-low seven-segment digits. The top digit shows the sign or the error mark.
//
// Ports:
//   CLOCK_50  in   1         rising-edge clock
//   RESET     in   1         synchronous, active-high reset
//   SW        in   2*OPW     operands {A,B}
//   KEY       in   4         active-low buttons: [0] add, [1] sub, [2] mul, [3] clear
//   LEDR      out  2*OPW     result magnitude in binary
//   NEG       out  1         result negative (sub with A<B)
//   OVF       out  1         magnitude does not fit the DIGITS-1 magnitude digits
//   BUSY      out  1         conversion in progress
//   HEX       out  7*DIGITS  segments {g..a} per digit, digit 0 least significant
//
// Build option:
//   LZ_BLANK_EN  When defined, leading zero magnitude digits are blanked. Digit 0 is always shown.
module calc_bcd_seq #(
  parameter int OPW    = 5,
  parameter int DIGITS = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [2*OPW-1:0]      SW,
  input  logic [3:0]            KEY,
  output logic [2*OPW-1:0]      LEDR,
  output logic                  NEG,
  output logic                  OVF,
  output logic                  BUSY,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int RW  = 2 * OPW;
  localparam int NB  = (RW * 3) / 10 + 1;  // enough BCD digits for 2^RW-1
  localparam int SHW = 4 * NB + RW;        // {bcd digits, binary} shift register
  localparam int CW  = $clog2(RW + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RW - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CONV = 2'd2
  } state_t;

  state_t            state_r;
  logic [3:0]        key_meta_r;
  logic [3:0]        key_sync_r;
  logic [3:0]        key_prev_r;
  logic [OPW-1:0]    a_r;
  logic [OPW-1:0]    b_r;
  logic [1:0]        op_r;
  logic [SHW-1:0]    shift_r;
  logic [CW-1:0]     cnt_r;

  logic [3:0]        press_s;
  logic [1:0]        op_sel_s;
  logic [RW-1:0]     res_s;
  logic              res_neg_s;
  logic [SHW-1:0]    load_step_s;
  logic [SHW-1:0]    conv_step_s;
  logic              conv_ovf_s;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift the whole register left.
  function automatic logic [SHW-1:0] dabble(input logic [SHW-1:0] v);
    logic [SHW-1:0] t;
    t = v;
    for (int i = 0; i < NB; i++) begin
      if (t[RW+4*i +: 4] >= 4'd5) begin
        t[RW+4*i +: 4] = t[RW+4*i +: 4] + 4'd3;
      end
    end
    return {t[SHW-2:0], 1'b0};
  endfunction

  // Any BCD digit that has no magnitude digit on the display means overflow.
  function automatic logic ovf_of(input logic [4*NB-1:0] bcd);
    logic o;
    o = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if ((i >= DIGITS - 1) && (bcd[4*i +: 4] != 4'd0)) begin
        o = 1'b1;
      end
    end
    return o;
  endfunction

  function automatic logic [7*DIGITS-1:0] build_hex(input logic [4*NB-1:0] bcd,
                                                    input logic neg, input logic ovf);
    logic [7*DIGITS-1:0]     h;
    logic [4*(NB+DIGITS)-1:0] bx;  // zero-padded so every display digit has a source
    logic [3:0]              d;
`ifdef LZ_BLANK_EN
    logic                    seen;
    seen = 1'b0;
`endif
    h  = '1;
    bx = {{(4*DIGITS){1'b0}}, bcd};
    if (ovf) begin
      h[7*(DIGITS-1) +: 7] = SEG_E;
    end else begin
      h[7*(DIGITS-1) +: 7] = neg ? SEG_DASH : SEG_BLANK;
      for (int i = DIGITS - 2; i >= 0; i--) begin
        d = bx[4*i +: 4];
`ifdef LZ_BLANK_EN
        if ((d != 4'd0) || (i == 0)) begin
          seen = 1'b1;
        end
        if (seen) begin
          h[7*i +: 7] = seg7(d);
        end
`else
        h[7*i +: 7] = seg7(d);
`endif
      end
    end
    return h;
  endfunction

  // Falling edge of a synchronised key gives a one-cycle press pulse. Lower index wins.
  always_comb begin
    press_s = key_prev_r & ~key_sync_r;
    if (press_s[0]) begin
      op_sel_s = 2'd0;
    end else if (press_s[1]) begin
      op_sel_s = 2'd1;
    end else if (press_s[2]) begin
      op_sel_s = 2'd2;
    end else begin
      op_sel_s = 2'd3;
    end
  end

  // Arithmetic on the latched operands; every result fits in RW bits.
  always_comb begin
    res_s     = '0;
    res_neg_s = 1'b0;
    case (op_r)
      2'd0: res_s = RW'(a_r) + RW'(b_r);
      2'd1: begin
        if (a_r >= b_r) begin
          res_s = RW'(a_r) - RW'(b_r);
        end else begin
          res_s     = RW'(b_r) - RW'(a_r);
          res_neg_s = 1'b1;
        end
      end
      2'd2: res_s = RW'(a_r) * RW'(b_r);
      default: res_s = '0;
    endcase
  end

  // The first conversion step runs in LOAD, so CONV needs RW-1 further steps.
  always_comb begin
    load_step_s = dabble({{(4*NB){1'b0}}, res_s});
    conv_step_s = dabble(shift_r);
    conv_ovf_s  = ovf_of(conv_step_s[SHW-1:RW]);
  end

  // Key synchronisers, the operation FSM and all registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_meta_r <= 4'b1111;
      key_sync_r <= 4'b1111;
      key_prev_r <= 4'b1111;
      state_r    <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= 2'd0;
      shift_r    <= '0;
      cnt_r      <= '0;
      LEDR       <= '0;
      NEG        <= 1'b0;
      OVF        <= 1'b0;
      BUSY       <= 1'b0;
      HEX        <= build_hex('0, 1'b0, 1'b0);
    end else begin
      key_meta_r <= KEY;
      key_sync_r <= key_meta_r;
      key_prev_r <= key_sync_r;
      case (state_r)
        IDLE: begin
          if (|press_s) begin
            a_r     <= SW[2*OPW-1:OPW];
            b_r     <= SW[OPW-1:0];
            op_r    <= op_sel_s;
            BUSY    <= 1'b1;
            state_r <= LOAD;
          end
        end
        LOAD: begin
          LEDR    <= res_s;
          NEG     <= res_neg_s;
          shift_r <= load_step_s;
          cnt_r   <= CW'(1);
          state_r <= CONV;
        end
        CONV: begin
          shift_r <= conv_step_s;
          if (cnt_r == CNT_LAST) begin
            // The display only changes here, so partial BCD values never reach HEX.
            HEX     <= build_hex(conv_step_s[SHW-1:RW], NEG, conv_ovf_s);
            OVF     <= conv_ovf_s;
            BUSY    <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_bcd_seq.sv
// Self-checking bench for calc_bcd_seq.
// It uses an OPW=5 instance for most cases and an OPW=7 instance for the overflow case.
module tb_calc_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [9:0]  ledr;
  logic        neg, ovf, busy;
  logic [27:0] hex;
  logic [13:0] sw7;
  logic [3:0]  key7;
  logic [13:0] ledr7;
  logic        neg7, ovf7, busy7;
  logic [27:0] hex7;

  always #5 clk = ~clk;

  calc_bcd_seq #(.OPW(5), .DIGITS(4)) dut (
    .CLOCK_50(clk), .RESET(rst), .SW(sw), .KEY(key),
    .LEDR(ledr), .NEG(neg), .OVF(ovf), .BUSY(busy), .HEX(hex)
  );

  calc_bcd_seq #(.OPW(7), .DIGITS(4)) dut7 (
    .CLOCK_50(clk), .RESET(rst), .SW(sw7), .KEY(key7),
    .LEDR(ledr7), .NEG(neg7), .OVF(ovf7), .BUSY(busy7), .HEX(hex7)
  );

  typedef struct {
    int          ledr;
    bit          neg;
    bit          ovf;
    logic [27:0] hex;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Expected 4-digit display for a magnitude and sign.
  function automatic logic [27:0] exp_hex(input int mag, input bit ng);
    logic [27:0] h;
    h = '1;
    if (mag > 999) begin
      h[27:21] = 7'b0000110;
    end else begin
      h[27:21] = ng ? 7'b0111111 : 7'b1111111;
      h[6:0]   = seg(mag % 10);
`ifdef LZ_BLANK_EN
      if (mag >= 10)  h[13:7]  = seg((mag / 10) % 10);
      if (mag >= 100) h[20:14] = seg(mag / 100);
`else
      h[13:7]  = seg((mag / 10) % 10);
      h[20:14] = seg(mag / 100);
`endif
    end
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation, push its expectation, wait for BUSY to fall, then pop and compare.
  task automatic run_op(input string nm, input int a, input int b, input logic [3:0] mask,
                        input bit use7, input bit inject, input bit hold);
    exp_t        e;
    int          op, bc, rw;
    bit          seen, stable;
    logic        b_s;
    logic [27:0] h0;
    op = mask[0] ? 0 : mask[1] ? 1 : mask[2] ? 2 : 3;
    e.neg = 1'b0;
    case (op)
      0: e.ledr = a + b;
      1: begin
        if (a >= b) e.ledr = a - b;
        else begin e.ledr = b - a; e.neg = 1'b1; end
      end
      2: e.ledr = a * b;
      default: e.ledr = 0;
    endcase
    e.ovf = (e.ledr > 999);
    e.hex = exp_hex(e.ledr, e.neg);
    sb.push_back(e);
    rw = use7 ? 14 : 10;
    h0 = use7 ? hex7 : hex;
    if (use7) begin
      sw7  = {7'(a), 7'(b)};
      key7 = ~mask;
    end else begin
      sw  = {5'(a), 5'(b)};
      key = ~mask;
    end
    bc = 0; seen = 1'b0; stable = 1'b1; b_s = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      b_s = use7 ? busy7 : busy;
      if (b_s) begin
        seen = 1'b1;
        bc++;
        if ((use7 ? hex7 : hex) !== h0) stable = 1'b0;
        if (inject && bc == 3) key[1] = 1'b0;
      end else if (seen) begin
        break;
      end
    end
    check({nm, "_done"}, {31'd0, seen & ~b_s}, 32'd1);
    e = sb.pop_front();
    check({nm, "_ledr"}, use7 ? 32'(ledr7) : 32'(ledr), e.ledr);
    check({nm, "_neg"}, use7 ? 32'(neg7) : 32'(neg), 32'(e.neg));
    check({nm, "_ovf"}, use7 ? 32'(ovf7) : 32'(ovf), 32'(e.ovf));
    check({nm, "_hex"}, use7 ? 32'(hex7) : 32'(hex), 32'(e.hex));
    check({nm, "_busy_cycles"}, bc, rw);
    check({nm, "_hex_stable"}, {31'd0, stable}, 32'd1);
    if (!hold) begin
      key  = 4'b1111;
      key7 = 4'b1111;
      tick();
      tick();
    end
  endtask

  initial begin
    int bc, extra;
    rst = 1'b1; sw = '0; key = 4'b1111; sw7 = '0; key7 = 4'b1111;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_ledr", ledr, 0);
    check("rst_neg", neg, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_hex", hex, exp_hex(0, 1'b0));
    check("rst7_hex", hex7, exp_hex(0, 1'b0));
    check("rst7_busy", busy7, 0);

    run_op("add", 17, 9, 4'b0001, 1'b0, 1'b0, 1'b0);
    run_op("sub", 3, 20, 4'b0010, 1'b0, 1'b0, 1'b0);

    // Abort a multiply in its 5th CONV cycle; the display must return to reset state.
    sw = {5'd31, 5'd31};
    key = 4'b1011;
    bc = 0;
    for (int i = 0; i < 40 && bc < 6; i++) begin
      tick();
      if (busy) bc++;
    end
    check("abort_reached", bc, 6);
    rst = 1'b1;
    key = 4'b1111;
    tick();
    check("abort_busy", busy, 0);
    check("abort_ledr", ledr, 0);
    check("abort_neg", neg, 0);
    check("abort_hex", hex, exp_hex(0, 1'b0));
    rst = 1'b0;
    repeat (3) tick();

    run_op("mul", 31, 31, 4'b0100, 1'b0, 1'b0, 1'b0);
    run_op("clr", 31, 31, 4'b1000, 1'b0, 1'b0, 1'b0);
    run_op("mul_ovf", 127, 127, 4'b0100, 1'b1, 1'b0, 1'b0);
    run_op("sub_eq", 12, 12, 4'b0010, 1'b0, 1'b0, 1'b0);

    // KEY0 and KEY2 together, KEY1 pressed during BUSY, keys held afterwards.
    run_op("prio", 4, 5, 4'b0101, 1'b0, 1'b1, 1'b1);
    extra = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (busy) extra++;
    end
    check("hold_one_op", extra, 0);
    key = 4'b1111;
    repeat (4) tick();
    check("hold_ledr", ledr, 9);
    check("hold_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
